seven_seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment driver for the board display, generalised to NUM_DIGITS physical digits and VAL_DIGITS decimal value digits.
- Binary-to-BCD conversion is sequential: a load-triggered iterative double-dabble engine with a busy flag.
- The visible window scrolls with the edit cursor.
- Adds cursor blink, leading-zero blanking, a per-digit decimal-point mask and overflow indication.
- Sits between the UI/menu FSM and the board seg/an/dp pins.

---
 rtl/seven_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment driver: sequential double-dabble BCD conversion, scrolling cursor window, blink, blanking, DP mask.
// Optional anode dimming (brightness input) is enabled by defining SEVSEG_DIM_EN.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int VAL_DIGITS  = 6,
    parameter int VAL_WIDTH   = 20,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_WIDTH-1:0]  value,
    input  logic                  load,
    input  logic [2:0]            cursor,
    input  logic                  blink_en,
    input  logic                  lz_blank,
    input  logic [VAL_DIGITS-1:0] dp_mask,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int BW   = 4 * VAL_DIGITS;
    localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTW = $clog2(VAL_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state;
    logic [VAL_WIDTH-1:0] shreg;
    logic [BW-1:0]        acc;
    logic [BW-1:0]        adj;
    logic                 ovf_acc;
    logic [CNTW-1:0]      bit_cnt;
    logic [BW-1:0]        bcd_reg;

    always_comb begin
        adj = acc;
        for (int i = 0; i < VAL_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            bit_cnt  <= '0;
            bcd_reg  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg   <= value;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The top bit of the adjusted accumulator is lost by the shift: value needs more digits.
                    acc     <= {adj[BW-2:0], shreg[VAL_WIDTH-1]};
                    shreg   <= {shreg[VAL_WIDTH-2:0], 1'b0};
                    ovf_acc <= ovf_acc | adj[BW-1];
                    bit_cnt <= bit_cnt + CNTW'(1);
                    if (bit_cnt == CNTW'(VAL_WIDTH - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd_reg  <= acc;
                    overflow <= ovf_acc;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [RCW-1:0] ref_cnt;
    logic [SCW-1:0] scan_idx;
    logic [SCW-1:0] scan_nxt;
    logic [BCW-1:0] blink_cnt;
    logic           blink_on;
    logic           blink_nxt;
    logic           tick;
    logic           blink_wrap;

    assign tick       = (ref_cnt == RCW'(REFRESH_DIV - 1));
    assign blink_wrap = (blink_cnt == BCW'(BLINK_DIV - 1));
    assign scan_nxt   = (scan_idx == SCW'(NUM_DIGITS - 1)) ? '0 : scan_idx + SCW'(1);
    assign blink_nxt  = (tick && blink_wrap) ? ~blink_on : blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt   <= '0;
            scan_idx  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick) begin
            ref_cnt   <= '0;
            scan_idx  <= scan_nxt;
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BCW'(1);
            blink_on  <= blink_nxt;
        end else begin
            ref_cnt <= ref_cnt + RCW'(1);
        end
    end

    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        case (v)
            4'd0:    seg_enc = 7'h40;
            4'd1:    seg_enc = 7'h79;
            4'd2:    seg_enc = 7'h24;
            4'd3:    seg_enc = 7'h30;
            4'd4:    seg_enc = 7'h19;
            4'd5:    seg_enc = 7'h12;
            4'd6:    seg_enc = 7'h02;
            4'd7:    seg_enc = 7'h78;
            4'd8:    seg_enc = 7'h00;
            4'd9:    seg_enc = 7'h10;
            default: seg_enc = 7'h7F;
        endcase
    endfunction

    // Next-slot contents, computed for the slot that becomes active at the coming tick.
    logic [3:0]            cur_c;
    logic [3:0]            base;
    logic [3:0]            d;
    logic [3:0]            digit;
    logic                  dp_bit;
    logic                  upper_zero;
    logic                  blank;
    logic [VAL_DIGITS:0]   hz;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        cur_c = {1'b0, cursor};
        if (cur_c > 4'(VAL_DIGITS - 1))
            cur_c = 4'(VAL_DIGITS - 1);

        base = '0;
        if (cur_c > 4'(NUM_DIGITS - 1))
            base = cur_c - 4'(NUM_DIGITS - 1);
        if (base > 4'(VAL_DIGITS - NUM_DIGITS))
            base = 4'(VAL_DIGITS - NUM_DIGITS);

        d = base + 4'(scan_nxt);

        // hz[i]: value digits i..top are all zero.
        hz = '1;
        for (int i = VAL_DIGITS - 1; i >= 0; i--)
            hz[i] = hz[i+1] && (bcd_reg[4*i +: 4] == 4'd0);

        digit      = '0;
        dp_bit     = 1'b0;
        upper_zero = 1'b0;
        for (int i = 0; i < VAL_DIGITS; i++) begin
            if (d == 4'(i)) begin
                digit      = bcd_reg[4*i +: 4];
                dp_bit     = dp_mask[i];
                upper_zero = hz[i];
            end
        end

        blank = (lz_blank && (d != 4'd0) && (d > cur_c) && upper_zero) ||
                (blink_en && (d == cur_c) && !blink_nxt);

        if (overflow) begin
            seg_nxt = 7'h3F;
            dp_nxt  = 1'b1;
        end else begin
            seg_nxt = blank ? 7'h7F : seg_enc(digit);
            dp_nxt  = ~dp_bit;
        end
        an_nxt = ~(NUM_DIGITS'(1) << scan_nxt);
    end

    logic [NUM_DIGITS-1:0] an_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg  <= 7'h7F;
            an_q <= '1;
            dp   <= 1'b1;
        end else if (tick) begin
            seg  <= seg_nxt;
            an_q <= an_nxt;
            dp   <= dp_nxt;
        end
    end

`ifdef SEVSEG_DIM_EN
    logic [31:0] thr_new;
    logic [31:0] thr_q;
    logic        dim_on;

    assign thr_new = (({28'd0, brightness} + 32'd1) * 32'(REFRESH_DIV)) >> 4;

    // dim_on reflects whether the refresh count of the current cycle is below the slot threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q  <= '0;
            dim_on <= 1'b0;
        end else if (tick) begin
            thr_q  <= thr_new;
            dim_on <= (thr_new != 32'd0);
        end else begin
            dim_on <= ((32'(ref_cnt) + 32'd1) < thr_q);
        end
    end

    assign an = an_q | {NUM_DIGITS{~dim_on}};
`else
    assign an = an_q;
`endif

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a short refresh period so scan slots last 4 cycles.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int VD = 6;
    localparam int VW = 20;
    localparam int RD = 4;
    // Blink half-period of 4 ticks equals one scan round, so slot 1 alternates on successive visits.
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic [2:0]    cursor = 3'd0;
    logic          blink_en = 1'b0;
    logic          lz_blank = 1'b0;
    logic [VD-1:0] dp_mask = '0;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          dp;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND), .VAL_DIGITS(VD), .VAL_WIDTH(VW), .REFRESH_DIV(RD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .cursor(cursor),
        .blink_en(blink_en), .lz_blank(lz_blank), .dp_mask(dp_mask),
`ifdef SEVSEG_DIM_EN
        .brightness(4'd15),
`endif
        .busy(busy), .overflow(overflow), .seg(seg), .an(an), .dp(dp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_slot(input int k);
        logic [ND-1:0] exp_an;
        logic          found;
        exp_an = ~(4'b0001 << k);
        found  = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an === exp_an) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            errors++;
            $error("FAIL wait_slot%0d: an=%b never selected slot", k, an);
        end
    endtask

    task automatic check_slot(input string tag, input int k, input logic [6:0] exp_seg, input logic exp_dp);
        wait_slot(k);
        chk({tag, "_seg"}, seg, exp_seg);
        chk({tag, "_dp"}, dp, exp_dp);
    endtask

    task automatic do_load(input logic [VW-1:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle_settle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            vectors++;
            errors++;
            $error("FAIL busy_timeout: busy stuck high");
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [6:0] s0, s1, s2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_dp", dp, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_tick_an", an, 4'hF);
        chk("pre_tick_seg", seg, 7'h7F);

        // 1: 123456, cursor 0, busy for VW+1 cycles
        do_load(20'd123456);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 21);
        chk("t1_ovf", overflow, 1'b0);
        repeat (20) @(negedge clk);
        check_slot("t1_s0", 0, 7'h02, 1'b1);
        check_slot("t1_s1", 1, 7'h12, 1'b1);
        check_slot("t1_s2", 2, 7'h19, 1'b1);
        check_slot("t1_s3", 3, 7'h30, 1'b1);

        // 2: cursor 5 scrolls window to digits 2..5, DP after digit 2
        cursor  = 3'd5;
        dp_mask = 6'b000100;
        repeat (20) @(negedge clk);
        check_slot("t2_s0", 0, 7'h19, 1'b0);
        check_slot("t2_s1", 1, 7'h30, 1'b1);
        check_slot("t2_s2", 2, 7'h24, 1'b1);
        check_slot("t2_s3", 3, 7'h79, 1'b1);

        // 3: leading-zero blanking, then cursor 3 un-blanks digits up to the cursor
        dp_mask  = '0;
        cursor   = 3'd0;
        lz_blank = 1'b1;
        do_load(20'd42);
        wait_idle_settle();
        check_slot("t3_s0", 0, 7'h24, 1'b1);
        check_slot("t3_s1", 1, 7'h19, 1'b1);
        check_slot("t3_s2", 2, 7'h7F, 1'b1);
        check_slot("t3_s3", 3, 7'h7F, 1'b1);
        cursor = 3'd3;
        repeat (20) @(negedge clk);
        check_slot("t3c_s2", 2, 7'h40, 1'b1);
        check_slot("t3c_s3", 3, 7'h40, 1'b1);

        // 4: overflow shows dashes with DP dark, then a max in-range value clears it
        lz_blank = 1'b0;
        cursor   = 3'd0;
        dp_mask  = '1;
        do_load(20'hFFFFF);
        wait_idle_settle();
        chk("t4_ovf", overflow, 1'b1);
        check_slot("t4_s0", 0, 7'h3F, 1'b1);
        check_slot("t4_s3", 3, 7'h3F, 1'b1);
        dp_mask = '0;
        do_load(20'd999999);
        wait_idle_settle();
        chk("t4_ovf_clr", overflow, 1'b0);
        check_slot("t4b_s0", 0, 7'h10, 1'b1);
        check_slot("t4b_s3", 3, 7'h10, 1'b1);

        // 5: load while busy ignored, then cursor blink on slot 1
        blink_en = 1'b1;
        cursor   = 3'd1;
        do_load(20'd123456);
        repeat (3) @(negedge clk);
        value = 20'd999999;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("t5_busy", busy, 1'b1);
        wait_idle_settle();
        check_slot("t5_keep_s0", 0, 7'h02, 1'b1);
        wait_slot(1);
        s0 = seg;
        wait_slot(2);
        wait_slot(1);
        s1 = seg;
        wait_slot(2);
        wait_slot(1);
        s2 = seg;
        chk("t5_blink_alt", ((s0 == 7'h12 && s1 == 7'h7F) || (s0 == 7'h7F && s1 == 7'h12)), 1'b1);
        chk("t5_blink_period", s2, s0);
        check_slot("t5_steady_s0", 0, 7'h02, 1'b1);
        check_slot("t5_steady_s2", 2, 7'h19, 1'b1);

        // 6: reset during SHIFT aborts conversion and clears bcd_reg
        blink_en = 1'b0;
        cursor   = 3'd0;
        do_load(20'd654321);
        repeat (9) @(negedge clk);
        chk("t6_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_an", an, 4'hF);
        chk("t6_seg", seg, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_busy_post", busy, 1'b0);
        chk("t6_ovf", overflow, 1'b0);
        check_slot("t6_s0", 0, 7'h40, 1'b1);
        check_slot("t6_s3", 3, 7'h40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
